serial_adder_ctrl: RTL

//  Bit-serial adder sequencer: accepts two WIDTH-bit operands plus carry-in, feeds them
//  LSB-first through one instance of full_adder_1b, one bit per clock, and assembles the sum.

---
 rtl/serial_adder_ctrl.sv | 131 +++++++++++++
 1 files changed

// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial adder sequencer around a single 1-bit full adder
// Optional subtract mode enabled by defining SERIAL_SUB_EN (adds the sub input port).

module full_adder_1b (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);
    assign o_s = i_a ^ i_b ^ i_c;
    assign o_c = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_s_sr;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    logic             w_fa_s;
    logic             w_fa_c;
    logic [WIDTH-1:0] w_s_next;
    logic [WIDTH-1:0] w_b_load;
    logic             w_c_load;

    // Subtraction is a + ~b + 1; cout then reads as "no borrow".
`ifdef SERIAL_SUB_EN
    assign w_b_load = sub ? ~b : b;
    assign w_c_load = sub ? 1'b1 : cin;
`else
    assign w_b_load = b;
    assign w_c_load = cin;
`endif

    full_adder_1b u_fa (
        .i_a (r_a_sr[0]),
        .i_b (r_b_sr[0]),
        .i_c (r_carry),
        .o_s (w_fa_s),
        .o_c (w_fa_c)
    );

    // Sum bits enter at the MSB so that after WIDTH shifts bit 0 lands at the LSB.
    generate
        if (WIDTH == 1) begin : g_w1
            assign w_s_next = w_fa_s;
        end else begin : g_wn
            assign w_s_next = {w_fa_s, r_s_sr[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a_sr  <= '0;
            r_b_sr  <= '0;
            r_s_sr  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a_sr  <= a;
                        r_b_sr  <= w_b_load;
                        r_carry <= w_c_load;
                        r_s_sr  <= '0;
                        r_cnt   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_a_sr  <= r_a_sr >> 1;
                    r_b_sr  <= r_b_sr >> 1;
                    r_s_sr  <= w_s_next;
                    r_carry <= w_fa_c;
                    r_cnt   <= r_cnt + CW'(1);
                    if (r_cnt == LAST_CNT) begin
                        r_sum   <= w_s_next;
                        r_cout  <= w_fa_c;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = (r_state != S_IDLE);
    assign done = (r_state == S_DONE);
    assign sum  = r_sum;
    assign cout = r_cout;

endmodule
